// File: rtl/alu.sv
// rtl/alu.sv - combinational ALU with registered result and zero flag
// Optional carry-out and registered carry enabled by defining ALU_CARRY_EN.
module alu #(
  parameter int data_width   = 8,
  parameter int opcode_width = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [opcode_width-1:0] opcode,
  input  logic [data_width-1:0]   in_a,
  input  logic [data_width-1:0]   in_b,
  output logic                    zero,
  output logic [data_width-1:0]   alu_out,
  output logic [data_width-1:0]   alu_out_r,
`ifdef ALU_CARRY_EN
  output logic                    carry_out,
  output logic                    carry_r,
`endif
  output logic                    zero_r
);

  logic                  upper_nz;
  logic [data_width-1:0] add_sum;

  // Opcodes wider than 3 bits fall back to passing in_a when any upper bit is set.
  generate
    if (opcode_width > 3) begin : g_upper
      assign upper_nz = |opcode[opcode_width-1:3];
    end else begin : g_no_upper
      assign upper_nz = 1'b0;
    end
  endgenerate

`ifdef ALU_CARRY_EN
  logic add_carry;
  assign {add_carry, add_sum} = {1'b0, in_a} + {1'b0, in_b};
`else
  assign add_sum = in_a + in_b;
`endif

  assign zero = ~|in_a;

  always_comb begin
    alu_out = in_a;
    if (!upper_nz) begin
      case (opcode[2:0])
        3'd2:    alu_out = add_sum;
        3'd3:    alu_out = in_a & in_b;
        3'd4:    alu_out = in_a ^ in_b;
        3'd5:    alu_out = in_b;
        default: alu_out = in_a;
      endcase
    end
  end

`ifdef ALU_CARRY_EN
  assign carry_out = add_carry & ~upper_nz & (opcode[2:0] == 3'd2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) carry_r <= 1'b0;
    else        carry_r <= carry_out;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_out_r <= '0;
      zero_r    <= 1'b0;
    end else begin
      alu_out_r <= alu_out;
      zero_r    <= zero;
    end
  end

endmodule

// File: tb/tb_alu.sv
// tb/tb_alu.sv - randomized self-checking bench for alu against a reference model
module tb_alu;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] opcode;
  logic [3:0] opcode4;
  logic [7:0] in_a, in_b;
  logic       zero, zero_r, zero4, zero4_r;
  logic [7:0] alu_out, alu_out_r, alu_out4, alu_out4_r;
`ifdef ALU_CARRY_EN
  logic carry_out, carry_r, carry4, carry4_r;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu #(.data_width(8), .opcode_width(3)) u_dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .in_a(in_a), .in_b(in_b),
    .zero(zero), .alu_out(alu_out), .alu_out_r(alu_out_r),
`ifdef ALU_CARRY_EN
    .carry_out(carry_out), .carry_r(carry_r),
`endif
    .zero_r(zero_r)
  );

  alu #(.data_width(8), .opcode_width(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode4), .in_a(in_a), .in_b(in_b),
    .zero(zero4), .alu_out(alu_out4), .alu_out_r(alu_out4_r),
`ifdef ALU_CARRY_EN
    .carry_out(carry4), .carry_r(carry4_r),
`endif
    .zero_r(zero4_r)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model(input int op, input int a, input int b);
    case (op)
      2:       return 8'((a + b) % 256);
      3:       return 8'(a & b);
      4:       return 8'(a ^ b);
      5:       return 8'(b);
      default: return 8'(a);
    endcase
  endfunction

  function automatic logic model_carry(input int op, input int a, input int b);
    return (op == 2) && (a + b > 255);
  endfunction

  task automatic drive(input int op, input int a, input int b);
    opcode  = 3'(op);
    opcode4 = 4'(op);
    in_a    = 8'(a);
    in_b    = 8'(b);
    #1;
  endtask

  task automatic check_comb(input string tag, input int op, input int a, input int b);
    check({tag, ".out"}, 32'(alu_out), 32'(model(op, a, b)));
    check({tag, ".zero"}, 32'(zero), 32'(a == 0));
`ifdef ALU_CARRY_EN
    check({tag, ".carry"}, 32'(carry_out), 32'(model_carry(op, a, b)));
`endif
  endtask

  initial begin
    int op, a, b, op4;
    logic [7:0] exp_r;
    logic       exp_z;
    logic       exp_c;
    rst_n = 1'b1;
    drive(2, 8'h42, 8'h86);
    rst_n = 1'b0;
    #1;
    check("reset.out_r", 32'(alu_out_r), 32'h0);
    check("reset.zero_r", 32'(zero_r), 32'h0);
    check("reset.comb_out", 32'(alu_out), 32'hC8);

    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors with in_a=0x42, in_b=0x86 across all opcodes.
    for (int o = 0; o < 8; o++) begin
      drive(o, 8'h42, 8'h86);
      check_comb($sformatf("dir.op%0d", o), o, 8'h42, 8'h86);
    end
    drive(2, 8'h42, 8'h86); check("dir.add", 32'(alu_out), 32'hC8);
    drive(3, 8'h42, 8'h86); check("dir.and", 32'(alu_out), 32'h02);
    drive(4, 8'h42, 8'h86); check("dir.xor", 32'(alu_out), 32'hC4);
    drive(7, 8'h00, 8'h86); check("dir.op7z.out", 32'(alu_out), 32'h00);
    check("dir.op7z.zero", 32'(zero), 32'h1);
    drive(2, 8'h00, 8'h86); check("dir.addz.out", 32'(alu_out), 32'h86);
    check("dir.addz.zero", 32'(zero), 32'h1);
    drive(2, 8'hFF, 8'h01); check("dir.wrap.out", 32'(alu_out), 32'h00);
    check("dir.wrap.zero", 32'(zero), 32'h0);
`ifdef ALU_CARRY_EN
    check("dir.wrap.carry", 32'(carry_out), 32'h1);
    @(posedge clk); #1;
    check("dir.wrap.carry_r", 32'(carry_r), 32'h1);
    @(negedge clk);
`endif

    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      op  = int'($urandom_range(0, 7));
      a   = (i % 10 == 0) ? 0 : int'($urandom_range(0, 255));
      b   = int'($urandom_range(0, 255));
      op4 = int'($urandom_range(0, 15));
      drive(op, a, b);
      opcode4 = 4'(op4);
      #1;
      check_comb("rnd", op, a, b);
      check("rnd4.out", 32'(alu_out4), 32'((op4 > 7) ? 8'(a) : model(op4, a, b)));
      check("rnd4.zero", 32'(zero4), 32'(a == 0));
      exp_r = model(op, a, b);
      exp_z = (a == 0);
      exp_c = model_carry(op, a, b);
      @(posedge clk); #1;
      check("rnd.out_r", 32'(alu_out_r), 32'(exp_r));
      check("rnd.zero_r", 32'(zero_r), 32'(exp_z));
`ifdef ALU_CARRY_EN
      check("rnd.carry_r", 32'(carry_r), 32'(exp_c));
`else
      if (exp_c) n_tests += 0;
`endif
    end

    // Asynchronous reset in mid-cycle, then recovery on the next edge.
    @(negedge clk);
    drive(2, 8'h00, 8'hC8);
    @(posedge clk); #1;
    check("rst.pre.out_r", 32'(alu_out_r), 32'hC8);
    check("rst.pre.zero_r", 32'(zero_r), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("rst.mid.out_r", 32'(alu_out_r), 32'h0);
    check("rst.mid.zero_r", 32'(zero_r), 32'h0);
    check("rst.mid.comb_out", 32'(alu_out), 32'hC8);
    check("rst.mid.comb_zero", 32'(zero), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    drive(2, 8'h42, 8'h86);
    @(posedge clk); #1;
    check("rst.post.out_r", 32'(alu_out_r), 32'hC8);
    check("rst.post.zero_r", 32'(zero_r), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 Parameter data_width, default 8, operand/result width in bits (SHALL be >= 1).
REQ-002 Parameter opcode_width, default 3, opcode width in bits (SHALL be >= 3).
REQ-003 clk  input  1  single clock; rising edge samples registered outputs.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 opcode  input  opcode_width  operation select.
REQ-006 in_a  input  data_width  operand A (accumulator side).
REQ-007 in_b  input  data_width  operand B (memory/data side).
REQ-008 zero  output  1  combinational: 1 iff in_a is all zeros.
REQ-009 alu_out  output  data_width  combinational operation result.
REQ-010 alu_out_r  output  data_width  alu_out registered on clk.
REQ-011 zero_r  output  1  zero registered on clk.

Function
REQ-012 alu_out SHALL be purely combinational from opcode, in_a, in_b; settles within the same delta-time, no clock dependency.
REQ-013 Opcode 0 (PASS0) -> alu_out = in_a.
REQ-014 Opcode 1 (PASS1) -> alu_out = in_a.
REQ-015 Opcode 2 (ADD) -> alu_out = (in_a + in_b) mod 2^data_width; carry discarded on alu_out.
REQ-016 Opcode 3 (AND) -> alu_out = in_a & in_b, bitwise.
REQ-017 Opcode 4 (XOR) -> alu_out = in_a ^ in_b, bitwise.
REQ-018 Opcode 5 (PASSB) -> alu_out = in_b.
REQ-019 Opcodes 6, 7 (PASS6, PASS7) -> alu_out = in_a.
REQ-020 Opcode bits above bit 2 (when opcode_width > 3): any nonzero upper bit -> alu_out = in_a.
REQ-021 zero SHALL depend only on in_a, never on opcode, in_b or alu_out (e.g. ADD with in_a=0, in_b=5 -> zero=1, alu_out=5).
REQ-022 X/Z on opcode SHALL not be required to produce defined output; all defined inputs SHALL yield fully defined (no X) outputs.
REQ-023 On each rising clk edge with rst_n high: alu_out_r <= alu_out, zero_r <= zero; latency exactly one cycle.

Reset
REQ-024 rst_n low SHALL immediately (asynchronously) force alu_out_r=0, zero_r=0 (and carry_r=0 when configured).
REQ-025 Reset SHALL NOT affect combinational zero, alu_out or carry_out.
REQ-026 Release of rst_n SHALL take effect at the next rising clk edge; first capture reflects inputs at that edge.

Configuration
REQ-027 Macro ALU_CARRY_EN defined: extra ports carry_out (output, 1, combinational carry-out of ADD, 0 for all other opcodes) and carry_r (output, 1, carry_out registered, reset 0).
REQ-028 ALU_CARRY_EN undefined: carry_out and carry_r ports and logic SHALL not exist; all other behaviour identical.

Verification
REQ-029 in_a=8'h42, in_b=8'h86, opcode 0,1,6,7 -> alu_out=8'h42, zero=0; opcode 5 -> alu_out=8'h86, zero=0.
REQ-030 in_a=8'h42, in_b=8'h86: ADD -> 8'hC8, AND -> 8'h02, XOR -> 8'hC4, zero=0 each.
REQ-031 opcode 7, in_a=8'h00, in_b=8'h86 -> alu_out=8'h00, zero=1; ADD same operands -> alu_out=8'h86, zero=1.
REQ-032 ADD in_a=8'hFF, in_b=8'h01 -> alu_out=8'h00, zero=0; with ALU_CARRY_EN carry_out=1, carry_r=1 after next edge.
REQ-033 Assert rst_n low mid-cycle after registering 8'hC8 -> alu_out_r=0, zero_r=0 immediately without clk; release, one edge with ADD 8'h42+8'h86 -> alu_out_r=8'hC8.
